// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: pipeline writeback (A) vs buffered MDU results (B).
// Keeps a pending-write scoreboard for RAW/WAW hazards, with starvation relief for B.
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        a_we,
  input  logic [4:0]  a_wn,
  input  logic [31:0] a_d,
  output logic        a_hold,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wn,
  output logic        iss_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_wn,
  input  logic [31:0] b_d,
  output logic        b_ready,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic        raw_stall,
  output logic        we,
  output logic [4:0]  wn,
  output logic [31:0] d,
  output logic [31:0] pend
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [4:0]    r_fifo_wn [2];
  logic [31:0]   r_fifo_d  [2];
  logic          r_rd;
  logic          r_wr;
  logic [1:0]    r_count;
  logic [CW-1:0] r_starve;
  logic [31:0]   r_pend;

  logic        w_empty;
  logic        w_full;
  logic        w_sel_a;
  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [4:0]  w_head_wn;
  logic [31:0] w_head_d;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic [31:0] w_pend_nxt;

  assign w_empty   = (r_count == 2'd0);
  assign w_full    = (r_count == 2'd2);
  assign w_head_wn = r_fifo_wn[r_rd];
  assign w_head_d  = r_fifo_d[r_rd];

  assign a_hold  = !w_empty && (r_starve == CW'(STARVE_MAX));
  assign w_sel_a = a_we && !a_hold;
  assign w_pop   = !w_sel_a && !w_empty;

  assign b_ready = !w_full;
  assign w_push  = b_valid && b_ready;

  assign iss_ready = !r_pend[iss_wn] || (iss_wn == 5'd0);
  assign w_issue   = iss_valid && iss_ready && (iss_wn != 5'd0);

  assign raw_stall = ((rna != 5'd0) && r_pend[rna])
                  || ((rnb != 5'd0) && r_pend[rnb]);

  // r0 requests are still serviced; only the physical write is suppressed
  always_comb begin
    we = 1'b0;
    wn = 5'd0;
    d  = 32'd0;
    if (w_sel_a) begin
      we = (a_wn != 5'd0);
      wn = a_wn;
      d  = a_d;
    end else if (w_pop) begin
      we = (w_head_wn != 5'd0);
      wn = w_head_wn;
      d  = w_head_d;
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_issue) w_set[iss_wn] = 1'b1;
    if (w_pop)   w_clr[w_head_wn] = 1'b1;
    w_pend_nxt    = (r_pend & ~w_clr) | w_set;
    w_pend_nxt[0] = 1'b0;
  end

  assign pend = r_pend;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_count  <= 2'd0;
      r_starve <= '0;
      r_pend   <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (w_sel_a)
        r_starve <= r_starve + CW'(1);
    end
  end

  // Payload storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wn[r_wr] <= b_wn;
      r_fifo_d[r_wr]  <= b_d;
    end
  end

endmodule
